deser_flex: RTL and testbench
=============================

DESER_FLEX -- requirements
Module: deser_flex

Interface
REQ-001 The block SHALL have parameter DESER_W, default 16, meaning output word width in bits (legal: 2..64).
REQ-002 The block SHALL have parameter LANES, default 1, meaning serial bits accepted per valid beat (legal: 1, 2, 4; DESER_W divisible by LANES).
REQ-003 The block SHALL have parameter MSB_FIRST, default 1, meaning 1 = first received bit lands in word MSB, 0 = first received bit lands in word LSB.
REQ-004 The block SHALL have port clk_i, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port arst_n_i, input, 1, meaning reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port data_val_i, input, 1, meaning data_i carries a valid beat this cycle.
REQ-007 The block SHALL have port data_i, input, LANES, meaning serial beat; with MSB_FIRST=1 data_i[LANES-1] is the earliest bit, with MSB_FIRST=0 data_i[0] is the earliest bit.
REQ-008 The block SHALL have port flush_i, input, 1, meaning emit the partially assembled word.
REQ-009 The block SHALL have port deser_data_o, output, DESER_W, meaning assembled parallel word.
REQ-010 The block SHALL have port deser_data_val_o, output, 1, meaning single-cycle strobe qualifying deser_data_o.
REQ-011 The block SHALL have port deser_cnt_o, output, $clog2(DESER_W+1), meaning number of valid bits in deser_data_o (DESER_W for full words).

Function
REQ-012 The block SHALL keep a bit counter 0..DESER_W-LANES; each valid beat adds LANES bits to the shift register and increments the counter by LANES.
REQ-013 The block SHALL complete a word when the beat bringing the count to DESER_W is accepted; the counter SHALL then wrap to 0 in the same cycle, with no lost beat on back-to-back input.
REQ-014 The block SHALL assert deser_data_val_o exactly one cycle after the completing beat (core latency 1), with deser_cnt_o = DESER_W.
REQ-015 The block SHALL ignore idle cycles (data_val_i=0), i.e. gaps do not change the assembled word or counter.
REQ-016 On flush_i=1 with a nonzero bit count, the block SHALL emit the partial word next cycle with deser_cnt_o = bits held, then clear the counter.
REQ-017 With MSB_FIRST=1, partial-word valid bits SHALL occupy the top deser_cnt_o bits, the remaining bits zero; with MSB_FIRST=0 they SHALL occupy the bottom bits, upper bits zero.
REQ-018 For flush_i and data_val_i in the same cycle, the block SHALL include that beat first; if it completes the word, a single full word SHALL be emitted and flush has no further effect.
REQ-019 On flush_i with counter 0 and no valid beat, the block SHALL emit nothing.
REQ-020 The block SHALL hold deser_data_o and deser_cnt_o stable between strobes.

Reset
REQ-021 On arst_n_i low, the block SHALL immediately clear the counter, shift register, deser_data_o, deser_cnt_o and deser_data_val_o to 0, independent of clk_i.
REQ-022 The block SHALL discard a partially assembled word on reset; the first beat after release (first rising edge with arst_n_i high) starts a fresh word.

Configuration
REQ-023 With macro DESER_IO_REG_EN defined, the block SHALL add one register stage on data_val_i, data_i and flush_i and one on all outputs (reset by arst_n_i), giving total latency 3 cycles from input beat to strobe.
REQ-024 Without DESER_IO_REG_EN, inputs SHALL feed the core directly and total latency SHALL be 1 cycle; function is otherwise identical.

Verification
REQ-025 The bench SHALL cover: DESER_W=8, LANES=1, MSB_FIRST=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> deser_data_o=0xB2, cnt=8, strobe 1 cycle after 8th bit.
REQ-026 The bench SHALL cover: same bits with MSB_FIRST=0 and idle cycles inserted between bits -> 0x4D, single strobe.
REQ-027 The bench SHALL cover: DESER_W=8, LANES=2, MSB_FIRST=1, beats 2'b10, 2'b11, 2'b00, 2'b01 then 4 more beats back-to-back -> 0xB1 then second word with no gap.
REQ-028 The bench SHALL cover: DESER_W=8, LANES=1, MSB_FIRST=1, bits 1,0,1 then flush_i -> deser_data_o=0xA0, cnt=3; flush on empty -> no strobe.
REQ-029 The bench SHALL cover: 5 bits, arst_n_i low mid-cycle, release, 8 bits 0xFF -> outputs 0 during reset, one strobe with 0xFF.
REQ-030 The bench SHALL cover: REQ-025 stimulus with DESER_IO_REG_EN defined -> identical data, strobe 3 cycles after 8th bit.

Source files
------------

// File: rtl/deser_flex.sv
// Flexible serial-to-parallel deserializer: LANES bits per beat into DESER_W-bit words.
// Define DESER_IO_REG_EN to register inputs and outputs (total latency 3 instead of 1).
module deser_flex #(
   parameter int DESER_W   = 16,
   parameter int LANES     = 1,
   parameter int MSB_FIRST = 1
) (
   input  logic                             clk_i,
   input  logic                             arst_n_i,
   input  logic                             data_val_i,
   input  logic [LANES-1:0]                 data_i,
   input  logic                             flush_i,
   output logic [DESER_W-1:0]               deser_data_o,
   output logic                             deser_data_val_o,
   output logic [$clog2(DESER_W+1)-1:0]     deser_cnt_o
);

   localparam int CNT_W = $clog2(DESER_W + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DESER_W);
   localparam logic [CNT_W-1:0] STEP = CNT_W'(LANES);

   logic               val_c;
   logic               flush_c;
   logic [LANES-1:0]   data_c;

`ifdef DESER_IO_REG_EN
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         val_c   <= 1'b0;
         flush_c <= 1'b0;
         data_c  <= '0;
      end else begin
         val_c   <= data_val_i;
         flush_c <= flush_i;
         data_c  <= data_i;
      end
   end
`else
   assign val_c   = data_val_i;
   assign flush_c = flush_i;
   assign data_c  = data_i;
`endif

   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_sum;
   logic [CNT_W-1:0]   cnt_d;
   logic [DESER_W-1:0] sh_q;
   logic [DESER_W-1:0] sh_sum;
   logic [DESER_W-1:0] word_c;
   logic               emit_c;

   logic [DESER_W-1:0] core_data_q;
   logic [CNT_W-1:0]   core_cnt_q;
   logic               core_val_q;

   always_comb begin
      sh_sum  = sh_q;
      cnt_sum = cnt_q;
      if (val_c) begin
         if (MSB_FIRST != 0) sh_sum = (sh_q << LANES) | DESER_W'(data_c);
         else                sh_sum = (sh_q >> LANES) | (DESER_W'(data_c) << (DESER_W - LANES));
         cnt_sum = cnt_q + STEP;
      end
      emit_c = 1'b0;
      word_c = sh_sum;
      cnt_d  = cnt_sum;
      if (cnt_sum == FULL) begin
         emit_c = 1'b1;
         cnt_d  = '0;
      end else if (flush_c && (cnt_sum != '0)) begin
         emit_c = 1'b1;
         cnt_d  = '0;
         // Shifting the held bits to their edge also pushes out stale bits, zero-filling the rest
         if (MSB_FIRST != 0) word_c = sh_sum << (FULL - cnt_sum);
         else                word_c = sh_sum >> (FULL - cnt_sum);
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         cnt_q       <= '0;
         sh_q        <= '0;
         core_val_q  <= 1'b0;
         core_data_q <= '0;
         core_cnt_q  <= '0;
      end else begin
         cnt_q      <= cnt_d;
         sh_q       <= sh_sum;
         core_val_q <= emit_c;
         if (emit_c) begin
            core_data_q <= word_c;
            core_cnt_q  <= cnt_sum;
         end
      end
   end

`ifdef DESER_IO_REG_EN
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         deser_data_val_o <= 1'b0;
         deser_data_o     <= '0;
         deser_cnt_o      <= '0;
      end else begin
         deser_data_val_o <= core_val_q;
         if (core_val_q) begin
            deser_data_o <= core_data_q;
            deser_cnt_o  <= core_cnt_q;
         end
      end
   end
`else
   assign deser_data_val_o = core_val_q;
   assign deser_data_o     = core_data_q;
   assign deser_cnt_o      = core_cnt_q;
`endif

endmodule

// File: tb/tb_deser_flex.sv
// Bench for deser_flex: three 8-bit configurations checked against a bit-queue reference model.
// Honours DESER_IO_REG_EN for the expected latency.
module tb_deser_flex;

`ifdef DESER_IO_REG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      int         due;
      logic [7:0] word;
      int         cnt;
   } exp_t;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic       arst_n;
   logic       v[3];
   logic       f[3];
   logic [1:0] d[3];
   logic [7:0] od[3];
   logic [3:0] oc[3];
   logic       ov[3];

   int   ln[3] = '{1, 1, 2};
   bit   ms[3] = '{1'b1, 1'b0, 1'b1};

   int   bq[3][$];
   exp_t eq[3][$];
   int   cap_d[3][$];
   int   cap_c[3][$];
   logic [7:0] last_d[3];
   logic [3:0] last_c[3];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   deser_flex #(.DESER_W(8), .LANES(1), .MSB_FIRST(1)) u_a (
      .clk_i(clk_i), .arst_n_i(arst_n), .data_val_i(v[0]), .data_i(d[0][0:0]), .flush_i(f[0]),
      .deser_data_o(od[0]), .deser_data_val_o(ov[0]), .deser_cnt_o(oc[0]));
   deser_flex #(.DESER_W(8), .LANES(1), .MSB_FIRST(0)) u_b (
      .clk_i(clk_i), .arst_n_i(arst_n), .data_val_i(v[1]), .data_i(d[1][0:0]), .flush_i(f[1]),
      .deser_data_o(od[1]), .deser_data_val_o(ov[1]), .deser_cnt_o(oc[1]));
   deser_flex #(.DESER_W(8), .LANES(2), .MSB_FIRST(1)) u_c (
      .clk_i(clk_i), .arst_n_i(arst_n), .data_val_i(v[2]), .data_i(d[2]), .flush_i(f[2]),
      .deser_data_o(od[2]), .deser_data_val_o(ov[2]), .deser_cnt_o(oc[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] pack(int k);
      logic [7:0] w = '0;
      for (int i = 0; i < bq[k].size(); i++) begin
         if (ms[k]) w[7-i] = (bq[k][i] != 0);
         else       w[i]   = (bq[k][i] != 0);
      end
      return w;
   endfunction

   function automatic int cap_at(int k, int i, bit want_cnt);
      if (want_cnt) return (i < cap_c[k].size()) ? cap_c[k][i] : -1;
      return (i < cap_d[k].size()) ? cap_d[k][i] : -1;
   endfunction

   // Reference model: bits collected in arrival order, packed when 8 arrive or on flush
   initial forever begin
      @(posedge clk_i);
      cyc++;
      for (int k = 0; k < 3; k++) begin
         if (!arst_n) begin
            bq[k].delete();
            eq[k].delete();
         end else begin
            if (v[k])
               for (int j = 0; j < ln[k]; j++)
                  bq[k].push_back(ms[k] ? int'(d[k][ln[k]-1-j]) : int'(d[k][j]));
            if (bq[k].size() == 8 || (f[k] && bq[k].size() > 0)) begin
               exp_t e;
               e.due  = cyc + LAT - 1;
               e.word = pack(k);
               e.cnt  = bq[k].size();
               eq[k].push_back(e);
               bq[k].delete();
            end
         end
      end
   end

   initial forever begin
      @(negedge clk_i);
      for (int k = 0; k < 3; k++) begin
         if (!arst_n) begin
            check($sformatf("rst_val[%0d]", k), 32'(ov[k]), 32'd0);
            check($sformatf("rst_data[%0d]", k), 32'(od[k]), 32'd0);
            check($sformatf("rst_cnt[%0d]", k), 32'(oc[k]), 32'd0);
            last_d[k] = '0;
            last_c[k] = '0;
         end else begin
            bit due;
            due = eq[k].size() > 0 && eq[k][0].due == cyc;
            check($sformatf("strobe[%0d]", k), 32'(ov[k]), 32'(due));
            if (due) begin
               check($sformatf("data[%0d]", k), 32'(od[k]), 32'(eq[k][0].word));
               check($sformatf("cnt[%0d]", k), 32'(oc[k]), 32'(eq[k][0].cnt));
               last_d[k] = eq[k][0].word;
               last_c[k] = 4'(eq[k][0].cnt);
               void'(eq[k].pop_front());
            end else begin
               check($sformatf("hold_data[%0d]", k), 32'(od[k]), 32'(last_d[k]));
               check($sformatf("hold_cnt[%0d]", k), 32'(oc[k]), 32'(last_c[k]));
            end
            if (ov[k]) begin
               cap_d[k].push_back(int'(od[k]));
               cap_c[k].push_back(int'(oc[k]));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_all();
      for (int k = 0; k < 3; k++) begin
         v[k] = 1'b0;
         f[k] = 1'b0;
         d[k] = '0;
      end
   endtask

   task automatic clear_caps();
      for (int k = 0; k < 3; k++) begin
         cap_d[k].delete();
         cap_c[k].delete();
      end
   endtask

   initial begin
      logic [7:0] pat;
      logic [1:0] cb[8];
      logic [4:0] pb;
      logic [1:0] fc[4];
      pat = 8'b1011_0010;
      cb  = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
      pb  = 5'b11011;
      fc  = '{2'b11, 2'b01, 2'b10, 2'b00};

      arst_n = 1'b0;
      idle_all();
      repeat (3) tick();
      arst_n = 1'b1;

      // Full words: A back-to-back bits, B with gaps, C two back-to-back 2-lane words
      clear_caps();
      for (int i = 0; i < 16; i++) begin
         idle_all();
         if (i < 8) begin
            v[0] = 1'b1; d[0] = {1'b0, pat[7-i]};
            v[2] = 1'b1; d[2] = cb[i];
         end
         if (i % 2 == 0) begin
            v[1] = 1'b1; d[1] = {1'b0, pat[7-i/2]};
         end
         tick();
      end
      idle_all();
      repeat (LAT + 2) tick();
      check("a_nwords", 32'(cap_d[0].size()), 32'd1);
      check("a_word", 32'(cap_at(0, 0, 0)), 32'h0B2);
      check("a_cnt", 32'(cap_at(0, 0, 1)), 32'd8);
      check("b_nwords", 32'(cap_d[1].size()), 32'd1);
      check("b_word", 32'(cap_at(1, 0, 0)), 32'h04D);
      check("c_nwords", 32'(cap_d[2].size()), 32'd2);
      check("c_word0", 32'(cap_at(2, 0, 0)), 32'h0B1);
      check("c_word1", 32'(cap_at(2, 1, 0)), 32'h06B);

      // Partial flushes, flush together with a completing beat, then flush on empty
      clear_caps();
      for (int i = 0; i < 6; i++) begin
         idle_all();
         if (i < 3)  begin v[0] = 1'b1; d[0] = {1'b0, pat[7-i]}; end
         if (i == 3) f[0] = 1'b1;
         if (i < 5)  begin v[1] = 1'b1; d[1] = {1'b0, pb[i]}; end
         if (i == 5) f[1] = 1'b1;
         if (i < 4)  begin v[2] = 1'b1; d[2] = fc[i]; end
         if (i == 3) f[2] = 1'b1;
         tick();
      end
      idle_all();
      tick();
      for (int k = 0; k < 3; k++) f[k] = 1'b1;
      tick();
      idle_all();
      repeat (LAT + 2) tick();
      check("fl_a_nwords", 32'(cap_d[0].size()), 32'd1);
      check("fl_a_word", 32'(cap_at(0, 0, 0)), 32'h0A0);
      check("fl_a_cnt", 32'(cap_at(0, 0, 1)), 32'd3);
      check("fl_b_word", 32'(cap_at(1, 0, 0)), 32'h01B);
      check("fl_b_cnt", 32'(cap_at(1, 0, 1)), 32'd5);
      check("fl_c_nwords", 32'(cap_d[2].size()), 32'd1);
      check("fl_c_word", 32'(cap_at(2, 0, 0)), 32'h0D8);
      check("fl_c_cnt", 32'(cap_at(2, 0, 1)), 32'd8);

      // Reset mid-word: partial bits discarded, outputs clear before any clock edge
      clear_caps();
      for (int i = 0; i < 5; i++) begin
         idle_all();
         v[0] = 1'b1; d[0] = {1'b0, i[0]};
         tick();
      end
      idle_all();
      #1;
      arst_n = 1'b0;
      #1;
      check("async_rst_data", 32'(od[0]), 32'd0);
      check("async_rst_cnt", 32'(oc[0]), 32'd0);
      check("async_rst_val", 32'(ov[0]), 32'd0);
      repeat (2) tick();
      arst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         v[0] = 1'b1; d[0] = 2'b01;
         tick();
      end
      idle_all();
      repeat (LAT + 2) tick();
      check("rst_a_nwords", 32'(cap_d[0].size()), 32'd1);
      check("rst_a_word", 32'(cap_at(0, 0, 0)), 32'h0FF);
      check("rst_a_cnt", 32'(cap_at(0, 0, 1)), 32'd8);

      // Random beats, gaps and flushes on all three instances
      for (int i = 0; i < 800; i++) begin
         for (int k = 0; k < 3; k++) begin
            v[k] = ($urandom_range(9) < 7);
            d[k] = 2'($urandom);
            f[k] = ($urandom_range(11) == 0);
         end
         tick();
      end
      idle_all();
      repeat (LAT + 3) tick();
      for (int k = 0; k < 3; k++)
         check($sformatf("drain[%0d]", k), 32'(eq[k].size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
